// File: rtl/testbasic7_feeder_if.sv
// Handshake bundle between the feeder, its command source
// and the TestBasic7 consumer.
interface testbasic7_feeder_if;
    logic [31:0] cmd_in;
    logic        cmd_in_sync;
    logic        cmd_in_notify;
    logic [31:0] b_out;
    logic        b_out_sync;
    logic        b_out_notify;
    logic [31:0] m_sent;
    logic        m_sent_notify;

    modport master (
        output cmd_in,
        output cmd_in_sync,
        input  cmd_in_notify,
        input  b_out,
        output b_out_sync,
        input  b_out_notify,
        input  m_sent,
        input  m_sent_notify
    );

    modport slave (
        input  cmd_in,
        input  cmd_in_sync,
        output cmd_in_notify,
        output b_out,
        input  b_out_sync,
        output b_out_notify,
        output m_sent,
        output m_sent_notify
    );
endinterface

// File: rtl/testbasic7_feeder.sv
// Burst producer: takes a start value, emits BURST_LEN
// arithmetic-sequence words, then publishes the burst count.
module testbasic7_feeder #(
    parameter int unsigned        BURST_LEN = 4,
    parameter logic signed [31:0] STEP      = 32'sd1
) (
    input logic                 clk,
    input logic                 rst,
    testbasic7_feeder_if.slave  bus
);

    if (BURST_LEN < 1 || BURST_LEN > 65535) begin : g_bad_len
        $error("BURST_LEN must be in 1..65535");
    end

    localparam logic [15:0] LEN = 16'(BURST_LEN);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t      state;
    logic [31:0] cur;
    logic [15:0] remaining;
    logic [31:0] bursts;
    logic        cmd_rdy;
    logic        out_vld;
    logic        sent_pls;

    // cur and bursts are registers, so these outputs stay registered
    assign bus.b_out         = cur;
    assign bus.m_sent        = bursts;
    assign bus.cmd_in_notify = cmd_rdy;
    assign bus.b_out_notify  = out_vld;
    assign bus.m_sent_notify = sent_pls;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur       <= '0;
            remaining <= '0;
            bursts    <= '0;
            cmd_rdy   <= 1'b1;
            out_vld   <= 1'b0;
            sent_pls  <= 1'b0;
        end else begin
            sent_pls <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_rdy && bus.cmd_in_sync) begin
                        cur       <= bus.cmd_in;
                        remaining <= LEN;
                        cmd_rdy   <= 1'b0;
                        out_vld   <= 1'b1;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_vld && bus.b_out_sync) begin
                        if (remaining > 16'd1) begin
                            cur       <= cur + STEP;
                            remaining <= remaining - 16'd1;
                        end else begin
                            bursts    <= bursts + 32'd1;
                            remaining <= '0;
                            sent_pls  <= 1'b1;
                            out_vld   <= 1'b0;
                            cmd_rdy   <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    cmd_rdy <= 1'b1;
                    out_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_testbasic7_feeder.sv
// Directed bench for testbasic7_feeder: default instance plus
// a negative-step, short-burst instance for wrap coverage.
module tb_testbasic7_feeder;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    testbasic7_feeder_if a_if ();
    testbasic7_feeder_if b_if ();

    testbasic7_feeder u_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    testbasic7_feeder #(
        .BURST_LEN (3),
        .STEP      (-3)
    ) u_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_idle_a(input string tag, input logic [31:0] sent,
                              input logic pulse);
        chk({tag, ".vld"}, 32'(a_if.b_out_notify), 32'd0);
        chk({tag, ".rdy"}, 32'(a_if.cmd_in_notify), 32'd1);
        chk({tag, ".sent"}, a_if.m_sent, sent);
        chk({tag, ".pls"}, 32'(a_if.m_sent_notify), 32'(pulse));
    endtask

    task automatic burst_a(input string tag, input logic [31:0] start);
        for (int i = 0; i < 4; i++) begin
            chk({tag, ".word"}, a_if.b_out, start + 32'(i));
            chk({tag, ".vld"}, 32'(a_if.b_out_notify), 32'd1);
            chk({tag, ".rdy"}, 32'(a_if.cmd_in_notify), 32'd0);
            tick();
        end
    endtask

    logic [31:0] exp_b [3];
    logic [31:0] exp_w;
    logic        bp [7];

    initial begin
        n_chk = 0;
        n_err = 0;
        exp_b = '{32'h8000_0001, 32'h7FFF_FFFE, 32'h7FFF_FFFB};
        bp    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        rst = 1'b1;
        a_if.cmd_in = 32'd77;
        a_if.cmd_in_sync = 1'b1;
        a_if.b_out_sync = 1'b1;
        b_if.cmd_in = 32'd0;
        b_if.cmd_in_sync = 1'b0;
        b_if.b_out_sync = 1'b1;

        // reset with a command pending
        tick();
        tick();
        chk_idle_a("rst", 32'd0, 1'b0);
        chk("rst.bout", a_if.b_out, 32'd0);
        a_if.cmd_in_sync = 1'b0;
        rst = 1'b0;
        tick();
        chk_idle_a("post_rst", 32'd0, 1'b0);

        // basic burst
        a_if.cmd_in = 32'd10;
        a_if.cmd_in_sync = 1'b1;
        tick();
        a_if.cmd_in_sync = 1'b0;
        burst_a("basic", 32'd10);
        chk_idle_a("basic_done", 32'd1, 1'b1);
        tick();
        chk_idle_a("basic_hold", 32'd1, 1'b0);

        // backpressure
        a_if.cmd_in_sync = 1'b1;
        tick();
        a_if.cmd_in_sync = 1'b0;
        exp_w = 32'd10;
        for (int i = 0; i < 7; i++) begin
            a_if.b_out_sync = bp[i];
            chk("bp.word", a_if.b_out, exp_w);
            chk("bp.vld", 32'(a_if.b_out_notify), 32'd1);
            tick();
            if (bp[i]) exp_w = exp_w + 32'd1;
        end
        a_if.b_out_sync = 1'b1;
        chk_idle_a("bp_done", 32'd2, 1'b1);

        // command held through EMIT
        a_if.cmd_in = 32'd5;
        a_if.cmd_in_sync = 1'b1;
        tick();
        a_if.cmd_in = 32'd100;
        burst_a("hold1", 32'd5);
        chk_idle_a("hold_gap", 32'd3, 1'b1);
        tick();
        a_if.cmd_in_sync = 1'b0;
        chk("hold2.pls", 32'(a_if.m_sent_notify), 32'd0);
        burst_a("hold2", 32'd100);
        chk_idle_a("hold_done", 32'd4, 1'b1);

        // reset mid-burst
        a_if.cmd_in = 32'd20;
        a_if.cmd_in_sync = 1'b1;
        tick();
        a_if.cmd_in_sync = 1'b0;
        chk("mid.w0", a_if.b_out, 32'd20);
        tick();
        chk("mid.w1", a_if.b_out, 32'd21);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle_a("mid_rst", 32'd0, 1'b0);
        chk("mid_rst.bout", a_if.b_out, 32'd0);
        tick();
        chk_idle_a("mid_after", 32'd0, 1'b0);
        a_if.cmd_in = 32'd30;
        a_if.cmd_in_sync = 1'b1;
        tick();
        a_if.cmd_in_sync = 1'b0;
        burst_a("mid_new", 32'd30);
        chk_idle_a("mid_new_done", 32'd1, 1'b1);

        // negative step with wrap
        b_if.cmd_in = 32'h8000_0001;
        b_if.cmd_in_sync = 1'b1;
        tick();
        b_if.cmd_in_sync = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("wrap.word", b_if.b_out, exp_b[i]);
            chk("wrap.vld", 32'(b_if.b_out_notify), 32'd1);
            tick();
        end
        chk("wrap.vld_end", 32'(b_if.b_out_notify), 32'd0);
        chk("wrap.pls", 32'(b_if.m_sent_notify), 32'd1);
        chk("wrap.sent", b_if.m_sent, 32'd1);
        chk("wrap.rdy", 32'(b_if.cmd_in_notify), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
